mem_port: RTL



---
 rtl/mem_port_pkg.sv | 51 +++++
 rtl/mem_port_align.sv | 62 ++++++
 rtl/mem_port.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared constants for the memory port: access-type codes, FSM states and
// the small decode helpers used by both the port and the lane aligner.
package mem_port_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b101
  } mt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Access width from the access type. Bit 2 only selects zero-extension for
  // loads, so stores see the same width decode; unlisted codes are words.
  function automatic size_e mt_size(input logic [2:0] mt);
    if (mt == MT_B || mt == MT_BU) begin
      return SZ_BYTE;
    end else if (mt == MT_H || mt == MT_HU) begin
      return SZ_HALF;
    end else begin
      return SZ_WORD;
    end
  endfunction

  // Only the unsigned byte/half loads zero-extend.
  function automatic logic mt_unsigned(input logic [2:0] mt);
    return (mt == MT_BU) || (mt == MT_HU);
  endfunction

  // Halves need an even address, words a word-aligned one.
  function automatic logic is_misaligned(input logic [2:0] mt, input logic [1:0] lane);
    case (mt_size(mt))
      SZ_HALF: return lane[0];
      SZ_WORD: return |lane;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_align.sv
// Byte-lane steering for a 32-bit little-endian word memory: extracts and
// extends load lanes, and produces store byte enables with lane-replicated
// write data. Purely combinational so a future cache can reuse it.
module mem_align
  import mem_port_pkg::*;
(
  input  logic [2:0]  mt,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_lanes,
  output logic [3:0]  byte_en,
  output logic        misaligned
);

  size_e       size;
  logic        zero_ext;
  logic [31:0] shifted;

  // Decode the access type once for both the load and store paths.
  always_comb begin
    size       = mt_size(mt);
    zero_ext   = mt_unsigned(mt);
    misaligned = is_misaligned(mt, lane);
  end

  // Bring the addressed lane down to bit 0 and sign- or zero-extend it; an
  // aligned word always has lane 0, so the shifted word is the word itself.
  always_comb begin
    shifted = rd_word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: ld_data = zero_ext ? {24'h000000, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = zero_ext ? {16'h0000, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Replicate the right-justified store data across every lane it could
  // land in and enable only the lanes the access actually covers.
  always_comb begin
    byte_en  = 4'b0000;
    st_lanes = wr_data;
    case (size)
      SZ_BYTE: begin
        byte_en  = 4'b0001 << lane;
        st_lanes = {4{wr_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{wr_data[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        st_lanes = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_port.sv
// Memory-side port of the mordor CPU: word-organised RAM behind a
// request/busy handshake with configurable wait states, byte/half/word lane
// steering and load extension. Each accepted request walks IDLE -> BUSY ->
// RESP; the control path stalls its micro-PC while busy is high.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        mem_ld,
  input  logic        mem_wr,
  input  logic [2:0]  mt,
  input  logic [31:0] data_input,
  output logic [31:0] data_output,
  output logic        busy,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_STATES);

  state_e        state;
  logic [CW-1:0] count;
  logic [AW+1:0] lat_addr;
  logic [2:0]    lat_mt;
  logic [31:0]   lat_data;
  logic          lat_store;

  logic          req;
  logic          commit;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [31:0]   st_lanes;
  logic [3:0]    byte_en;
  logic          access_mis;
  logic          unused_addr_hi;

  logic [31:0]   ram [DEPTH_WORDS];

  assign req            = mem_ld | mem_wr;
  assign word_idx       = lat_addr[AW+1:2];
  assign rd_word        = ram[word_idx];
  assign commit         = (state == ST_BUSY) && (count == '0);
  assign unused_addr_hi = ^address[31:AW+2];

  mem_align u_align (
    .mt         (lat_mt),
    .lane       (lat_addr[1:0]),
    .rd_word    (rd_word),
    .wr_data    (lat_data),
    .ld_data    (ld_data),
    .st_lanes   (st_lanes),
    .byte_en    (byte_en),
    .misaligned (access_mis)
  );

  // Access sequencer: latch the request in IDLE, count out the wait states
  // in BUSY, perform the access on the last BUSY cycle, then spend one RESP
  // cycle with busy low so the still-held request is not taken twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      lat_addr    <= '0;
      lat_mt      <= 3'b000;
      lat_data    <= 32'h0000_0000;
      lat_store   <= 1'b0;
      data_output <= 32'h0000_0000;
      misaligned  <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_addr  <= address[AW+1:0];
            lat_mt    <= mt;
            lat_data  <= data_input;
            lat_store <= mem_wr;
            count     <= WAIT_LOAD;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            state      <= ST_RESP;
            misaligned <= access_mis;
            if (!lat_store && !access_mis) begin
              data_output <= ld_data;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Store commit: merge the enabled lanes into the addressed word. A reset
  // on the commit edge or a misaligned access leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if (!reset && commit && lat_store && !access_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram[word_idx][8*i +: 8] <= st_lanes[8*i +: 8];
        end
      end
    end
  end

  // Busy rises in the same cycle a request appears in IDLE so the control
  // path stalls immediately, and stays high for the whole BUSY phase.
  always_comb begin
    busy = (state == ST_BUSY) || ((state == ST_IDLE) && req);
  end

endmodule
